// File: rtl/mod_pkg.sv
// Shared definitions for the repeated-subtraction modulus unit (control unit + datapath).
// Control codes are the {we, s} pair the control unit drives into the datapath.
package mod_pkg;

  localparam int MOD_WIDTH = 8;

  typedef enum logic [1:0] {
    ADD   = 2'b00,
    COMP  = 2'b01,
    SMALL = 2'b10,
    LARGE = 2'b11
  } cu_state_t;

  typedef logic [1:0] ctl_t;

  localparam ctl_t CTL_LOAD = 2'b10;
  localparam ctl_t CTL_STEP = 2'b11;
  localparam ctl_t CTL_IDLE = 2'b00;

endpackage

// File: rtl/mod_sub_cmp.sv
// Combinational subtract/compare of remainder against divisor; zero latency, no flow control.
module mod_sub_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             lt
);

  assign diff = r - b;
  assign lt   = (r < b);

endmodule

// File: rtl/mod_dp.sv
// Datapath for R = A mod B by repeated subtraction, one action per clock as decoded from {we, s}.
// x is purely registered-state based, so there is no combinational path from any input to it.
module mod_dp
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we,
  input  logic             s,
  input  logic             result,
  output logic             x,
  output logic [WIDTH-1:0] r,
  output logic             r_valid,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             div_zero
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff;
  logic             lt;
  ctl_t             ctl;

  mod_sub_cmp #(.WIDTH(WIDTH)) u_sub_cmp (
    .r    (r_q),
    .b    (b_q),
    .diff (diff),
    .lt   (lt)
  );

  // A zero divisor reports "done" so the control unit terminates with r = A.
  assign x   = lt | (b_q == '0);
  assign r   = r_q;
  assign ctl = {we, s};

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_q      <= '0;
      b_q      <= '0;
      iter_cnt <= '0;
      r_valid  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      r_valid <= result & ~we;
      if (ctl == CTL_LOAD) begin
        r_q      <= a;
        b_q      <= b;
        iter_cnt <= '0;
        div_zero <= (b == '0);
      end else if (ctl == CTL_STEP && !x) begin
        r_q <= diff;
        if (iter_cnt != '1) begin
          iter_cnt <= iter_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_dp.sv
// Bench for mod_dp: directed boundary scenarios plus random operands against an arithmetic model.
module tb_mod_dp;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] a, b;
  logic       we, s, result;
  logic       x, r_valid, div_zero;
  logic [7:0] r, iter_cnt;
  logic       x4, r_valid4, div_zero4;
  logic [7:0] r4;
  logic [3:0] iter_cnt4;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  mod_dp #(.WIDTH(8), .CNT_W(8)) dut (
    .CLK(CLK), .reset(reset), .a(a), .b(b), .we(we), .s(s), .result(result),
    .x(x), .r(r), .r_valid(r_valid), .iter_cnt(iter_cnt), .div_zero(div_zero)
  );

  mod_dp #(.WIDTH(8), .CNT_W(4)) dut4 (
    .CLK(CLK), .reset(reset), .a(a), .b(b), .we(we), .s(s), .result(result),
    .x(x4), .r(r4), .r_valid(r_valid4), .iter_cnt(iter_cnt4), .div_zero(div_zero4)
  );

  // Reference model: plain arithmetic on the operands.
  function automatic int model_rem(int aa, int bb);
    return (bb == 0) ? aa : aa % bb;
  endfunction

  function automatic int model_quot(int aa, int bb);
    return (bb == 0) ? 0 : aa / bb;
  endfunction

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic test_reset();
    reset = 1'b1; we = 1'b0; s = 1'b0; result = 1'b0; a = 8'd0; b = 8'd0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    vectors++;
    if (r !== 8'd0 || iter_cnt !== 8'd0 || r_valid !== 1'b0 || div_zero !== 1'b0 || x !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: r=%0d cnt=%0d rv=%0b dz=%0b x=%0b, want 0 0 0 0 1",
               r, iter_cnt, r_valid, div_zero, x);
    end
  endtask

  // Full operation as the control unit would sequence it: LOAD, STEP until x, final COMP, SMALL.
  task automatic test_operation(input int aa, input int bb);
    int steps;
    int exp_q;
    exp_q = model_quot(aa, bb);
    @(negedge CLK);
    we = 1'b1; s = 1'b0; result = 1'b0; a = aa[7:0]; b = bb[7:0];
    @(negedge CLK);
    vectors++;
    if (r !== aa[7:0] || iter_cnt !== 8'd0 || r_valid !== 1'b0 || div_zero !== (bb == 0) ||
        x !== (aa < bb || bb == 0)) begin
      miscompares++;
      $display("FAIL load(%0d,%0d): r=%0d cnt=%0d rv=%0b dz=%0b x=%0b", aa, bb, r, iter_cnt,
               r_valid, div_zero, x);
    end
    steps = 0;
    s = 1'b1;
    while (x !== 1'b1 && steps < 300) begin
      @(negedge CLK);
      steps++;
    end
    @(negedge CLK);
    we = 1'b0; s = 1'b0; result = 1'b1;
    vectors++;
    if (steps !== exp_q || r !== model_rem(aa, bb) || iter_cnt !== sat(exp_q, 255) ||
        iter_cnt4 !== sat(exp_q, 15) || x !== 1'b1 || r_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL op(%0d,%0d): steps=%0d r=%0d cnt=%0d cnt4=%0d x=%0b rv=%0b want steps=%0d r=%0d",
               aa, bb, steps, r, iter_cnt, iter_cnt4, x, r_valid, exp_q, model_rem(aa, bb));
    end
    @(negedge CLK);
    vectors++;
    if (r_valid !== 1'b1 || r4 !== model_rem(aa, bb)) begin
      miscompares++;
      $display("FAIL r_valid(%0d,%0d): rv=%0b r4=%0d want 1 %0d", aa, bb, r_valid, r4,
               model_rem(aa, bb));
    end
  endtask

  task automatic test_directed();
    test_operation(17, 5);
    test_operation(3, 9);
    test_operation(200, 0);
    test_operation(8, 8);
    test_operation(255, 1);
    test_operation(0, 7);
  endtask

  task automatic test_reset_mid_op();
    @(negedge CLK);
    we = 1'b1; s = 1'b0; result = 1'b0; a = 8'd100; b = 8'd7;
    @(negedge CLK);
    s = 1'b1;
    repeat (5) @(negedge CLK);
    vectors++;
    if (r !== 8'd65 || iter_cnt !== 8'd5) begin
      miscompares++;
      $display("FAIL mid_op: r=%0d cnt=%0d want 65 5", r, iter_cnt);
    end
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0; we = 1'b0; s = 1'b0;
    vectors++;
    if (r !== 8'd0 || iter_cnt !== 8'd0 || r_valid !== 1'b0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: r=%0d cnt=%0d rv=%0b dz=%0b want 0 0 0 0", r, iter_cnt, r_valid,
               div_zero);
    end
    test_operation(20, 6);
  endtask

  task automatic test_reload_and_hold();
    logic [7:0] r_hold, c_hold;
    logic       dz_hold, x_hold;
    test_operation(50, 6);
    @(negedge CLK);
    we = 1'b1; s = 1'b0; result = 1'b0; a = 8'd9; b = 8'd4;
    @(negedge CLK);
    vectors++;
    if (r_valid !== 1'b0 || r !== 8'd9 || iter_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reload: rv=%0b r=%0d cnt=%0d want 0 9 0", r_valid, r, iter_cnt);
    end
    s = 1'b1;
    repeat (2) @(negedge CLK);
    repeat (3) @(negedge CLK);
    vectors++;
    if (r !== 8'd1 || iter_cnt !== 8'd2 || x !== 1'b1) begin
      miscompares++;
      $display("FAIL extra_steps: r=%0d cnt=%0d x=%0b want 1 2 1", r, iter_cnt, x);
    end
    we = 1'b0; s = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    r_hold = r; c_hold = iter_cnt; dz_hold = div_zero; x_hold = x;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
    end
    vectors++;
    if (r !== 8'd1 || iter_cnt !== 8'd2 || div_zero !== 1'b0 || x !== 1'b1 ||
        r !== r_hold || iter_cnt !== c_hold || div_zero !== dz_hold || x !== x_hold) begin
      miscompares++;
      $display("FAIL hold: r=%0d cnt=%0d dz=%0b x=%0b want 1 2 0 1", r, iter_cnt, div_zero, x);
    end
    s = 1'b0;
  endtask

  task automatic test_random();
    int aa, bb;
    for (int i = 0; i < 25; i++) begin
      aa = $urandom_range(0, 255);
      bb = (i % 2 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      test_operation(aa, bb);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_reload_and_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
